sync_fifo_fwft: RTL and testbench

Single-clock, first-word-fall-through FIFO that sits directly behind `axis_fifo_bridge`. It accepts the bridge's `fifo_wr_*` outputs and returns `fifo_full`, and it drives `fifo_rd_data`/`fifo_empty` back to the bridge. The head word is always presented on `rd_data` while `empty` is low, so the bridge can use it combinationally, with no read-request latency. Status outputs (count, almost flags, error pulses) are registered for use by the control and status logic.

---
 rtl/sync_fifo_fwft.sv | 153 +++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: a DEPTH-entry array behind a head
// register that presents the oldest word on rd_data whenever empty is low.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_reject,
  output logic                  rd_reject
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH     = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_TH     = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  wr_reject_q, wr_reject_d;
  logic                  rd_reject_q, rd_reject_d;

  logic wr_acc_s;
  logic rd_acc_s;
  logic arr_empty_s;
  logic head_load_wr_s;
  logic mem_we_s;

  // Request qualification; count includes the head, so the array is empty at count <= 1.
  always_comb begin
    wr_acc_s       = wr_en && !full_q && !clear;
    rd_acc_s       = rd_en && !empty_q && !clear;
    arr_empty_s    = (count_q <= CNT_ONE);
    head_load_wr_s = wr_acc_s && (empty_q || (rd_acc_s && arr_empty_s));
    mem_we_s       = wr_acc_s && !head_load_wr_s;
  end

  // Next-state for pointers, head, occupancy, flags and reject pulses.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    head_d         = head_q;
    full_d         = full_q;
    empty_d        = empty_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    wr_reject_d    = 1'b0;
    rd_reject_d    = 1'b0;
    if (clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = CNT_ZERO;
      full_d         = 1'b0;
      empty_d        = 1'b1;
      almost_full_d  = 1'b0;
      almost_empty_d = 1'b1;
    end else begin
      if (mem_we_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s && !arr_empty_s) begin
        head_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end else if (head_load_wr_s) begin
        head_d   = wr_data;
        rd_ptr_d = rd_ptr_q;
      end else begin
        head_d   = head_q;
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      full_d         = (count_d == CNT_DEPTH);
      empty_d        = (count_d == CNT_ZERO);
      almost_full_d  = (count_d >= AF_TH);
      almost_empty_d = (count_d <= AE_TH);
      wr_reject_d    = wr_en && full_q;
      rd_reject_d    = rd_en && empty_q;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= CNT_ZERO;
      head_q         <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_reject_q    <= 1'b0;
      rd_reject_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      head_q         <= head_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      wr_reject_q    <= wr_reject_d;
      rd_reject_q    <= rd_reject_d;
    end
  end

  assign rd_data      = head_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign wr_reject    = wr_reject_q;
  assign rd_reject    = rd_reject_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft at default parameters (DEPTH=16).
module tb_sync_fifo_fwft;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          clear;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          wr_reject;
  logic          rd_reject;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          clr;
    logic          we;
    logic          re;
    logic [DW-1:0] d;
    int            cnt;
    logic [DW-1:0] dat;
    logic          cd;
    logic          wrj;
    logic          rdj;
  } vec_t;

  vec_t tbl [14];

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .wr_data(wr_data), .wr_en(wr_en), .full(full), .almost_full(almost_full),
    .rd_data(rd_data), .rd_en(rd_en), .empty(empty), .almost_empty(almost_empty),
    .count(count), .wr_reject(wr_reject), .rd_reject(rd_reject)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags are the documented functions of the expected occupancy.
  task automatic check_all(input string tag, input int cnt, input logic [DW-1:0] dat,
                           input logic cd, input logic wrj, input logic rdj);
    chk({tag, ".count"}, DW'(count), DW'(cnt));
    chk({tag, ".empty"}, DW'(empty), DW'(cnt == 0));
    chk({tag, ".full"}, DW'(full), DW'(cnt == DEPTH));
    chk({tag, ".almost_full"}, DW'(almost_full), DW'(cnt >= DEPTH - 2));
    chk({tag, ".almost_empty"}, DW'(almost_empty), DW'(cnt <= 2));
    chk({tag, ".wr_reject"}, DW'(wr_reject), DW'(wrj));
    chk({tag, ".rd_reject"}, DW'(rd_reject), DW'(rdj));
    if (cd) chk({tag, ".rd_data"}, rd_data, dat);
  endtask

  task automatic cyc(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    clear = c; wr_en = w; rd_en = r; wr_data = d;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'hA0, 1, 32'hA0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'hA1, 2, 32'hA0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'hA2, 3, 32'hA0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'hA3, 4, 32'hA0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h00, 3, 32'hA1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hA4, 3, 32'hA2, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h00, 2, 32'hA3, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1, 32'hA4, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h77, 1, 32'h77, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h55, 1, 32'h55, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1, 32'h55, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h99, 0, 32'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00, 0, 32'h00, 1'b0, 1'b0, 1'b0};

    aresetn = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(negedge aclk);
    check_all("reset_hold", 0, 32'h0, 1'b1, 1'b0, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_all("reset_release", 0, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].clr, tbl[i].we, tbl[i].re, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dat, tbl[i].cd, tbl[i].wrj, tbl[i].rdj);
    end

    // Fill to full, overflow once, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h10 + i);
      check_all($sformatf("fill%0d", i), i + 1, 32'h10, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'hFF);
    check_all("overflow", DEPTH, 32'h10, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check_all("overflow_after", DEPTH, 32'h10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h0);
      check_all($sformatf("drain%0d", i), DEPTH - 1 - i, 32'h11 + i, i < DEPTH - 1, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    check_all("clear_rd_empty", 0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Steady state at count 8 across several pointer wraps.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, DW'(i));
      check_all($sformatf("pre%0d", i), i + 1, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, 1'b1, DW'(8 + i));
      check_all($sformatf("steady%0d", i), 8, DW'(i + 1), 1'b1, 1'b0, 1'b0);
    end

    // Clear with words queued and a write pending, then async reset mid-burst.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check_all("clear_steady", 0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'hC0 + i);
      check_all($sformatf("q5_%0d", i), i + 1, 32'hC0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'hEE);
    check_all("clear_wr", 0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'hD0);
    cyc(1'b0, 1'b1, 1'b0, 32'hD1);
    check_all("burst", 2, 32'hD0, 1'b1, 1'b0, 1'b0);
    wr_data = 32'hD2;
    #2;
    aresetn = 1'b0;
    #1;
    check_all("async_reset", 0, 32'h0, 1'b1, 1'b0, 1'b0);
    wr_en = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 32'hE1);
    check_all("post_reset_wr", 1, 32'hE1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
